tile_brick_fetch: RTL

// - Upstream address generator and downstream pixel stage for the 20x20 brick-tile palette ROM (9-bit address, 12-bit colour).
// - Turns the VGA scan position plus the horizontal camera scroll into ROM read addresses for the ground band.
// - Registers the returned colour and replaces the key colour (transparent) with the sky colour.
// - Output feeds the colour mapper.
// - Uses no divider: per-frame iterative modulo, then per-pixel wrap counters.

---
 rtl/tile_brick_fetch_if.sv | 27 ++
 rtl/tile_brick_fetch.sv | 93 +++++++++
 2 files changed

// File: rtl/tile_brick_fetch_if.sv
// rtl/tile_brick_fetch_if.sv - scan-side and tile-ROM bus of the brick-tile fetch stage
interface tile_brick_fetch_if #(
  parameter int ADDR_W = 9
);
  logic              pixel_ce;
  logic              frame_start;
  logic              line_start;
  logic              de;
  logic [9:0]        DrawY;
  logic [11:0]       scroll_x;
  logic [9:0]        ground_top;
  logic [11:0]       tile_color;
  logic [ADDR_W-1:0] read_address;
  logic [11:0]       pixel_rgb;
  logic              pixel_valid;
  logic              phase_ready;

  modport master (
    output pixel_ce, frame_start, line_start, de, DrawY, scroll_x, ground_top, tile_color,
    input  read_address, pixel_rgb, pixel_valid, phase_ready
  );

  modport slave (
    input  pixel_ce, frame_start, line_start, de, DrawY, scroll_x, ground_top, tile_color,
    output read_address, pixel_rgb, pixel_valid, phase_ready
  );
endinterface

// File: rtl/tile_brick_fetch.sv
// rtl/tile_brick_fetch.sv - brick-tile ROM address generator and key-colour pixel stage
module tile_brick_fetch #(
  parameter int          TILE_W    = 20,
  parameter int          TILE_H    = 20,
  parameter int          ADDR_W    = 9,
  parameter logic [11:0] KEY_COLOR = 12'h808,
  parameter logic [11:0] SKY_COLOR = 12'h5AF
) (
  input logic             Clk,
  input logic             Reset_n,
  tile_brick_fetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MOD, RUN} state_t;

  state_t            state;
  logic [11:0]       rem;
  logic [4:0]        x_phase;
  logic [4:0]        tx;
  logic [4:0]        ty;
  logic              in_band_q;
  logic              s1_valid;
  logic              fire;
  logic [ADDR_W-1:0] ty_ext;
  logic [ADDR_W-1:0] addr_next;

  assign fire = bus.pixel_ce & bus.de;

  // ty*20 as (ty<<4)+(ty<<2) keeps the datapath multiplier-free
  always_comb begin
    ty_ext    = ADDR_W'(ty);
    addr_next = (ty_ext << 4) + (ty_ext << 2) + ADDR_W'(tx);
  end

  // Scroll phase = scroll_x mod TILE_W by repeated subtraction, once per frame
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state           <= IDLE;
      rem             <= '0;
      x_phase         <= '0;
      bus.phase_ready <= 1'b0;
    end else if (bus.frame_start) begin
      state           <= MOD;
      rem             <= bus.scroll_x;
      bus.phase_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= IDLE;
        MOD: begin
          if (rem >= 12'(TILE_W)) begin
            rem <= rem - 12'(TILE_W);
          end else begin
            x_phase         <= 5'(rem);
            state           <= RUN;
            bus.phase_ready <= 1'b1;
          end
        end
        RUN:     bus.phase_ready <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tx               <= '0;
      ty               <= '0;
      in_band_q        <= 1'b0;
      s1_valid         <= 1'b0;
      bus.read_address <= '0;
      bus.pixel_rgb    <= '0;
      bus.pixel_valid  <= 1'b0;
    end else begin
      s1_valid        <= fire;
      bus.pixel_valid <= s1_valid;
      if (bus.line_start) begin
        tx <= x_phase;
        if (bus.DrawY == bus.ground_top) begin
          ty <= '0;
        end else if (bus.DrawY > bus.ground_top) begin
          ty <= (ty == 5'(TILE_H - 1)) ? 5'd0 : ty + 5'd1;
        end
      end else if (fire) begin
        tx               <= (tx == 5'(TILE_W - 1)) ? 5'd0 : tx + 5'd1;
        bus.read_address <= addr_next;
        in_band_q        <= (bus.DrawY >= bus.ground_top) & bus.phase_ready;
      end
      // ROM data is valid one edge after read_address was registered
      if (s1_valid) begin
        bus.pixel_rgb <= (in_band_q && bus.tile_color != KEY_COLOR) ? bus.tile_color : SKY_COLOR;
      end
    end
  end
endmodule
